// File: rtl/axi4_lite_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite AR/R channel pair between IFU and LSU.
// One read outstanding at a time; grant is registered (no combinational IDLE grant).
//
// state | meaning
// IDLE  | no transaction; arbitrate pending requests, all handshakes low
// ADDR  | owner's address presented on the bus AR channel
// DATA  | waiting for the bus R beat to be taken by the owner
module axi4_lite_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iIfuArValid,
  output logic                  oIfuArReady,
  input  logic [ADDR_WIDTH-1:0] iIfuArAddr,
  output logic                  oIfuRValid,
  input  logic                  iIfuRReady,
  output logic [DATA_WIDTH-1:0] oIfuRData,
  output logic [RESP_WIDTH-1:0] oIfuRResp,
  input  logic                  iLsuArValid,
  output logic                  oLsuArReady,
  input  logic [ADDR_WIDTH-1:0] iLsuArAddr,
  output logic                  oLsuRValid,
  input  logic                  iLsuRReady,
  output logic [DATA_WIDTH-1:0] oLsuRData,
  output logic [RESP_WIDTH-1:0] oLsuRResp,
  output logic                  oAxiArValid,
  input  logic                  iAxiArReady,
  output logic [ADDR_WIDTH-1:0] oAxiArAddr,
  input  logic                  iAxiRValid,
  output logic                  oAxiRReady,
  input  logic [DATA_WIDTH-1:0] iAxiRData,
  input  logic [RESP_WIDTH-1:0] iAxiRResp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;

  logic                  own_ar_valid;
  logic [ADDR_WIDTH-1:0] own_ar_addr;
  logic                  own_r_ready;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_LSU;  // first tie after reset goes to IFU
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    own_ar_valid = (owner_q == OWN_LSU) ? iLsuArValid : iIfuArValid;
    own_ar_addr  = (owner_q == OWN_LSU) ? iLsuArAddr  : iIfuArAddr;
    own_r_ready  = (owner_q == OWN_LSU) ? iLsuRReady  : iIfuRReady;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    oIfuArReady = 1'b0;
    oLsuArReady = 1'b0;
    oIfuRValid  = 1'b0;
    oLsuRValid  = 1'b0;
    oIfuRData   = '0;
    oIfuRResp   = '0;
    oLsuRData   = '0;
    oLsuRResp   = '0;
    oAxiArValid = 1'b0;
    oAxiArAddr  = '0;
    oAxiRReady  = 1'b0;

    case (state_q)
      IDLE: begin
        if (iIfuArValid && iLsuArValid) begin
          owner_d = ~last_q;
          state_d = ADDR;
        end else if (iIfuArValid) begin
          owner_d = OWN_IFU;
          state_d = ADDR;
        end else if (iLsuArValid) begin
          owner_d = OWN_LSU;
          state_d = ADDR;
        end
      end

      ADDR: begin
        // An owner that drops ArValid keeps the grant; there is no re-arbitration here.
        oAxiArValid = own_ar_valid;
        oAxiArAddr  = own_ar_addr;
        if (owner_q == OWN_LSU) oLsuArReady = iAxiArReady;
        else                    oIfuArReady = iAxiArReady;
        if (own_ar_valid && iAxiArReady) state_d = DATA;
      end

      DATA: begin
        oAxiRReady = own_r_ready;
        oIfuRData  = iAxiRData;
        oIfuRResp  = iAxiRResp;
        oLsuRData  = iAxiRData;
        oLsuRResp  = iAxiRResp;
        if (owner_q == OWN_LSU) oLsuRValid = iAxiRValid;
        else                    oIfuRValid = iAxiRValid;
        if (iAxiRValid && own_r_ready) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_rd_arbiter.sv
// Bench for axi4_lite_rd_arbiter: requester agents, a bus responder and an
// order-checking scoreboard of expected grants and read returns.
module tb_axi4_lite_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 2;

  logic          iClock = 1'b0;
  logic          iReset;
  logic          iIfuArValid, oIfuArReady, oIfuRValid, iIfuRReady;
  logic [AW-1:0] iIfuArAddr;
  logic [DW-1:0] oIfuRData;
  logic [RW-1:0] oIfuRResp;
  logic          iLsuArValid, oLsuArReady, oLsuRValid, iLsuRReady;
  logic [AW-1:0] iLsuArAddr;
  logic [DW-1:0] oLsuRData;
  logic [RW-1:0] oLsuRResp;
  logic          oAxiArValid, iAxiArReady, iAxiRValid, oAxiRReady;
  logic [AW-1:0] oAxiArAddr;
  logic [DW-1:0] iAxiRData;
  logic [RW-1:0] iAxiRResp;

  always #5 iClock = ~iClock;

  axi4_lite_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) dut (
    .iClock(iClock), .iReset(iReset),
    .iIfuArValid(iIfuArValid), .oIfuArReady(oIfuArReady), .iIfuArAddr(iIfuArAddr),
    .oIfuRValid(oIfuRValid), .iIfuRReady(iIfuRReady), .oIfuRData(oIfuRData), .oIfuRResp(oIfuRResp),
    .iLsuArValid(iLsuArValid), .oLsuArReady(oLsuArReady), .iLsuArAddr(iLsuArAddr),
    .oLsuRValid(oLsuRValid), .iLsuRReady(iLsuRReady), .oLsuRData(oLsuRData), .oLsuRResp(oLsuRResp),
    .oAxiArValid(oAxiArValid), .iAxiArReady(iAxiArReady), .oAxiArAddr(oAxiArAddr),
    .iAxiRValid(iAxiRValid), .oAxiRReady(oAxiRReady), .iAxiRData(iAxiRData), .iAxiRResp(iAxiRResp)
  );

  typedef struct packed {
    logic          who;   // 0 = IFU, 1 = LSU
    logic [AW-1:0] addr;
  } exp_t;

  int            vec = 0;
  int            err = 0;
  int            ar_delay = 0;
  int            r_delay = 0;
  int            ifu_arhs_cnt = 0;
  int            ifu_rv_cnt = 0;
  int            lsu_rv_cnt = 0;
  logic [DW-1:0] last_ifu_data;
  logic [RW-1:0] last_ifu_resp;
  logic [AW-1:0] ifu_q[$];
  logic [AW-1:0] lsu_q[$];
  exp_t          exp_ar[$];
  exp_t          exp_r[$];

  function automatic logic [DW-1:0] bus_data(input logic [AW-1:0] a);
    return a ^ 32'h5EAD_BEEF;
  endfunction

  function automatic logic [RW-1:0] bus_resp(input logic [AW-1:0] a);
    return a[5:4];
  endfunction

  // Bus-side memory model: ArReady after ar_delay sightings of ArValid, RValid r_delay cycles after AR.
  initial begin : bus_model
    int            phase;
    int            cnt;
    logic          ar_hs, r_hs, av, rst;
    logic [AW-1:0] a_s, rd_addr;
    iAxiArReady = 1'b0; iAxiRValid = 1'b0; iAxiRData = '0; iAxiRResp = '0;
    phase = 0; cnt = 0; rd_addr = '0;
    forever begin
      @(negedge iClock);
      ar_hs = oAxiArValid && iAxiArReady;
      r_hs  = iAxiRValid && oAxiRReady;
      av    = oAxiArValid;
      rst   = iReset;
      a_s   = oAxiArAddr;
      @(posedge iClock); #1;
      if (rst) begin
        iAxiArReady = 1'b0; iAxiRValid = 1'b0; iAxiRData = '0; iAxiRResp = '0;
        phase = 0; cnt = 0;
      end else if (phase == 0) begin
        if (ar_hs) begin
          iAxiArReady = 1'b0;
          rd_addr = a_s;
          phase = 1;
          cnt = r_delay;
          if (cnt == 0) begin
            iAxiRValid = 1'b1; iAxiRData = bus_data(rd_addr); iAxiRResp = bus_resp(rd_addr);
          end
        end else if (av && !iAxiArReady) begin
          if (cnt >= ar_delay) iAxiArReady = 1'b1;
          else cnt++;
        end else if (!av) begin
          iAxiArReady = 1'b0;
          cnt = 0;
        end
      end else begin
        if (r_hs) begin
          iAxiRValid = 1'b0; iAxiRData = '0; iAxiRResp = '0;
          phase = 0; cnt = 0;
        end else if (!iAxiRValid) begin
          cnt--;
          if (cnt <= 0) begin
            iAxiRValid = 1'b1; iAxiRData = bus_data(rd_addr); iAxiRResp = bus_resp(rd_addr);
          end
        end
      end
    end
  end

  initial begin : ifu_agent
    logic hs;
    iIfuArValid = 1'b0; iIfuArAddr = '0;
    forever begin
      @(negedge iClock);
      hs = iIfuArValid && oIfuArReady;
      @(posedge iClock); #1;
      if (hs) begin
        iIfuArValid = 1'b0; iIfuArAddr = '0;
        ifu_q.delete(0);
      end
      if (!iIfuArValid && ifu_q.size() > 0 && !iReset) begin
        iIfuArValid = 1'b1; iIfuArAddr = ifu_q[0];
      end
    end
  end

  initial begin : lsu_agent
    logic hs;
    iLsuArValid = 1'b0; iLsuArAddr = '0;
    forever begin
      @(negedge iClock);
      hs = iLsuArValid && oLsuArReady;
      @(posedge iClock); #1;
      if (hs) begin
        iLsuArValid = 1'b0; iLsuArAddr = '0;
        lsu_q.delete(0);
      end
      if (!iLsuArValid && lsu_q.size() > 0 && !iReset) begin
        iLsuArValid = 1'b1; iLsuArAddr = lsu_q[0];
      end
    end
  end

  // Scoreboard: grants and read returns must come out in the pushed order.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge iClock);
      if (oAxiArValid && iAxiArReady) begin
        vec++;
        if (oIfuArReady) ifu_arhs_cnt++;
        if (exp_ar.size() == 0) begin
          err++;
          $display("FAIL ar_grant: unexpected grant addr=%h, expected none", oAxiArAddr);
        end else begin
          e = exp_ar.pop_front();
          if ({oIfuArReady, oLsuArReady, oAxiArAddr} !== {~e.who, e.who, e.addr}) begin
            err++;
            $display("FAIL ar_grant: got ifu_rdy=%b lsu_rdy=%b addr=%h, expected who=%0d addr=%h",
                     oIfuArReady, oLsuArReady, oAxiArAddr, e.who, e.addr);
          end
        end
      end
      if (oIfuRValid && oLsuRValid) begin
        vec++; err++;
        $display("FAIL rvalid_excl: both RValid high, expected at most one");
      end
      if (oIfuRValid && iIfuRReady) begin
        vec++;
        ifu_rv_cnt++;
        last_ifu_data = oIfuRData;
        last_ifu_resp = oIfuRResp;
        if (exp_r.size() == 0) begin
          err++;
          $display("FAIL ifu_r: unexpected beat data=%h, expected none", oIfuRData);
        end else begin
          e = exp_r.pop_front();
          if ({1'b0, oIfuRData, oIfuRResp} !== {e.who, bus_data(e.addr), bus_resp(e.addr)}) begin
            err++;
            $display("FAIL ifu_r: got data=%h resp=%0d, expected who=%0d data=%h resp=%0d",
                     oIfuRData, oIfuRResp, e.who, bus_data(e.addr), bus_resp(e.addr));
          end
        end
      end
      if (oLsuRValid && iLsuRReady) begin
        vec++;
        lsu_rv_cnt++;
        if (exp_r.size() == 0) begin
          err++;
          $display("FAIL lsu_r: unexpected beat data=%h, expected none", oLsuRData);
        end else begin
          e = exp_r.pop_front();
          if ({1'b1, oLsuRData, oLsuRResp} !== {e.who, bus_data(e.addr), bus_resp(e.addr)}) begin
            err++;
            $display("FAIL lsu_r: got data=%h resp=%0d, expected who=%0d data=%h resp=%0d",
                     oLsuRData, oLsuRResp, e.who, bus_data(e.addr), bus_resp(e.addr));
          end
        end
      end
    end
  end

  task automatic req(input logic who, input logic [AW-1:0] a);
    exp_t e;
    e.who = who;
    e.addr = a;
    exp_ar.push_back(e);
    exp_r.push_back(e);
    if (who) lsu_q.push_back(a);
    else     ifu_q.push_back(a);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (exp_r.size() != 0 && n < budget) begin
      @(negedge iClock);
      n++;
    end
    vec++;
    if (exp_r.size() != 0) begin
      err++;
      $display("FAIL %s_timeout: %0d reads pending, expected 0", name, exp_r.size());
      exp_r.delete(); exp_ar.delete(); ifu_q.delete(); lsu_q.delete();
    end
    @(negedge iClock);
  endtask

  task automatic do_reset();
    @(posedge iClock); #1;
    iReset = 1'b1;
    repeat (2) @(posedge iClock);
    #1 iReset = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b1; iIfuRReady = 1'b1; iLsuRReady = 1'b1;
    repeat (2) @(negedge iClock);
    vec++;
    if ({oAxiArValid, oAxiRReady, oIfuArReady, oLsuArReady, oIfuRValid, oLsuRValid} !== 6'b0) begin
      err++;
      $display("FAIL reset_hs: got %b, expected 000000",
               {oAxiArValid, oAxiRReady, oIfuArReady, oLsuArReady, oIfuRValid, oLsuRValid});
    end
    vec++;
    if (oAxiArAddr !== '0) begin
      err++; $display("FAIL reset_addr: got %h, expected 0", oAxiArAddr);
    end
    vec++;
    if ({oIfuRData, oIfuRResp, oLsuRData, oLsuRResp} !== '0) begin
      err++; $display("FAIL reset_data: got ifu=%h/%0d lsu=%h/%0d, expected 0",
                      oIfuRData, oIfuRResp, oLsuRData, oLsuRResp);
    end
    @(posedge iClock); #1 iReset = 1'b0;
    @(negedge iClock);
    vec++;
    if ({oAxiArValid, oAxiRReady, oIfuArReady, oLsuArReady} !== 4'b0) begin
      err++; $display("FAIL idle_hs: got %b, expected 0000",
                      {oAxiArValid, oAxiRReady, oIfuArReady, oLsuArReady});
    end
  endtask

  task automatic test_ifu_only();
    int a0, r0, l0;
    a0 = ifu_arhs_cnt; r0 = ifu_rv_cnt; l0 = lsu_rv_cnt;
    ar_delay = 1; r_delay = 2;
    req(1'b0, 32'h8000_0000);
    wait_done(60, "ifu_only");
    vec++;
    if (ifu_arhs_cnt - a0 != 1) begin
      err++; $display("FAIL ifu_only_arready: got %0d pulses, expected 1", ifu_arhs_cnt - a0);
    end
    vec++;
    if ({ifu_rv_cnt - r0, lsu_rv_cnt - l0} !== {32'd1, 32'd0}) begin
      err++; $display("FAIL ifu_only_rvalid: got ifu=%0d lsu=%0d, expected 1/0",
                      ifu_rv_cnt - r0, lsu_rv_cnt - l0);
    end
    vec++;
    if ({last_ifu_data, last_ifu_resp} !== {32'hDEAD_BEEF, 2'd0}) begin
      err++; $display("FAIL ifu_only_data: got %h/%0d, expected deadbeef/0", last_ifu_data, last_ifu_resp);
    end
    vec++;
    if ({oAxiArValid, oAxiRReady, oIfuArReady, oIfuRValid} !== 4'b0) begin
      err++; $display("FAIL ifu_only_idle: got %b, expected 0000",
                      {oAxiArValid, oAxiRReady, oIfuArReady, oIfuRValid});
    end
    ar_delay = 0;
  endtask

  task automatic test_tie();
    do_reset();
    r_delay = 1;
    @(negedge iClock);
    req(1'b0, 32'h0000_1000);
    req(1'b1, 32'h0000_2000);
    wait_done(60, "tie1");
    req(1'b0, 32'h0000_1010);
    req(1'b1, 32'h0000_2010);
    wait_done(60, "tie3");
  endtask

  task automatic test_back_to_back();
    int r0, l0;
    r0 = ifu_rv_cnt; l0 = lsu_rv_cnt;
    r_delay = 0;
    for (int i = 0; i < 3; i++) begin
      req(1'b0, 32'h0000_3000 + i * 32'h20);
      req(1'b1, 32'h0000_4000 + i * 32'h30);
    end
    wait_done(200, "fairness");
    vec++;
    if ({ifu_rv_cnt - r0, lsu_rv_cnt - l0} !== {32'd3, 32'd3}) begin
      err++; $display("FAIL fairness_count: got ifu=%0d lsu=%0d, expected 3/3",
                      ifu_rv_cnt - r0, lsu_rv_cnt - l0);
    end
  endtask

  task automatic test_rready_stall();
    int n = 0;
    r_delay = 0;
    iLsuRReady = 1'b0;
    req(1'b1, 32'h0000_6020);
    while (!oLsuRValid && n < 50) begin
      @(negedge iClock); n++;
    end
    req(1'b0, 32'h0000_6100);
    for (int i = 0; i < 3; i++) begin
      vec++;
      if ({oAxiRReady, oLsuRValid, oIfuArReady, oAxiArValid} !== 4'b0100) begin
        err++; $display("FAIL rready_stall[%0d]: got rrdy=%b lsu_rv=%b ifu_ardy=%b arv=%b, expected 0100",
                        i, oAxiRReady, oLsuRValid, oIfuArReady, oAxiArValid);
      end
      if (i < 2) @(negedge iClock);
    end
    @(posedge iClock); #1 iLsuRReady = 1'b1;
    @(negedge iClock);
    vec++;
    if (oAxiRReady !== 1'b1) begin
      err++; $display("FAIL rready_release: got %b, expected 1", oAxiRReady);
    end
    wait_done(60, "rready_stall");
  endtask

  task automatic test_ar_stall();
    int n = 0;
    ar_delay = 5; r_delay = 0;
    req(1'b0, 32'h0000_7030);
    while (!oAxiArValid && n < 50) begin
      @(negedge iClock); n++;
    end
    for (int i = 0; i < 5; i++) begin
      vec++;
      if ({oAxiArValid, oAxiRReady, oAxiArAddr} !== {1'b1, 1'b0, 32'h0000_7030}) begin
        err++; $display("FAIL ar_stall[%0d]: got arv=%b rrdy=%b addr=%h, expected 1/0/00007030",
                        i, oAxiArValid, oAxiRReady, oAxiArAddr);
      end
      @(negedge iClock);
    end
    wait_done(60, "ar_stall");
    ar_delay = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    r_delay = 4;
    req(1'b0, 32'h0000_5000);
    while (!oAxiRReady && n < 50) begin
      @(negedge iClock); n++;
    end
    @(posedge iClock); #1 iReset = 1'b1;
    @(posedge iClock); #1;
    exp_r.delete(); exp_ar.delete();
    @(negedge iClock);
    vec++;
    if ({oAxiArValid, oAxiRReady, oIfuArReady, oLsuArReady, oIfuRValid, oLsuRValid, oAxiArAddr} !== '0) begin
      err++; $display("FAIL reset_mid: got hs=%b addr=%h, expected 0",
                      {oAxiArValid, oAxiRReady, oIfuArReady, oLsuArReady, oIfuRValid, oLsuRValid}, oAxiArAddr);
    end
    @(posedge iClock); #1 iReset = 1'b0;
    @(negedge iClock);
    r_delay = 1;
    req(1'b0, 32'h0000_5040);
    wait_done(60, "after_reset");
  endtask

  initial begin
    test_reset();
    test_ifu_only();
    test_tie();
    test_back_to_back();
    test_rready_stall();
    test_ar_stall();
    test_reset_mid();
    repeat (3) @(negedge iClock);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/axi4_lite_rd_arbiter.md
Name: axi4_lite_rd_arbiter

Overview:
- Shares one AXI4-Lite read channel pair (AR/R) between two read requesters: the instruction fetch unit (IFU) and the load/store unit (LSU).
- Sits between the IFU/LSU read ports and the single AXI4-Lite master-side bus that goes to the memory/crossbar.
- Write channels (AW/W/B) are LSU-only and bypass this block.
- Round-robin arbitration; exactly one outstanding read at a time.

Parameters:
ADDR_WIDTH, 32, address width of all AR channels
DATA_WIDTH, 32, data width of all R channels
RESP_WIDTH, 2, width of rresp

Ports:
iClock  in  1  clock
iReset  in  1  synchronous active-high reset
iIfuArValid  in  1  IFU read request valid
oIfuArReady  out  1  IFU address accepted
iIfuArAddr  in  ADDR_WIDTH  IFU read address
oIfuRValid  out  1  IFU read data valid
iIfuRReady  in  1  IFU ready for read data
oIfuRData  out  DATA_WIDTH  IFU read data
oIfuRResp  out  RESP_WIDTH  IFU read response
iLsuArValid  in  1  LSU read request valid
oLsuArReady  out  1  LSU address accepted
iLsuArAddr  in  ADDR_WIDTH  LSU read address
oLsuRValid  out  1  LSU read data valid
iLsuRReady  in  1  LSU ready for read data
oLsuRData  out  DATA_WIDTH  LSU read data
oLsuRResp  out  RESP_WIDTH  LSU read response
oAxiArValid  out  1  bus AR valid
iAxiArReady  in  1  bus AR ready
oAxiArAddr  out  ADDR_WIDTH  bus AR address
iAxiRValid  in  1  bus R valid
oAxiRReady  out  1  bus R ready
iAxiRData  in  DATA_WIDTH  bus R data
iAxiRResp  in  RESP_WIDTH  bus R response

Behaviour:
- Registered state: FSM state (IDLE, ADDR, DATA), owner register (IFU/LSU), last-grant register.
- Reset: state=IDLE, owner=IFU, last-grant=LSU, so the first tie goes to IFU.
- While iReset=1 and in IDLE, every valid/ready output is 0 and every data/addr output is 0.
- IDLE:
  - All valid/ready outputs are 0; oAxiArAddr=0.
  - If exactly one requester has ArValid=1, it becomes owner.
  - If both have ArValid=1, owner is the requester that is not last-grant.
  - Any request present → go to ADDR next cycle. Arbitration latency is 1 cycle; there is no combinational IDLE grant.
- ADDR:
  - oAxiArValid = owner's ArValid; oAxiArAddr = owner's ArAddr.
  - Owner's ArReady = iAxiArReady; non-owner's ArReady = 0.
  - On oAxiArValid && iAxiArReady → DATA.
  - Requesters must hold ArValid/ArAddr stable until ArReady (AXI rule). If the owner drops ArValid anyway, stay in ADDR with oAxiArValid=0; no re-arbitration.
- DATA:
  - oAxiRReady = owner's RReady; owner's RValid = iAxiRValid; non-owner's RValid = 0.
  - RData/RResp to both requesters mirror iAxiRData/iAxiRResp; they are meaningful only with RValid.
  - On iAxiRValid && oAxiRReady → IDLE and last-grant ← owner.
- Non-owner requests stay pending with ArReady=0 and are served at the next IDLE.
- Back-to-back minimum period per read: IDLE + ADDR(≥1) + DATA(≥1) = 3 cycles.
- rresp is passed through unmodified; no error handling.
- Fairness: with both requesters held continuously, grants strictly alternate IFU, LSU, IFU, …
- Reset mid-operation (ADDR or DATA): next cycle is IDLE with all handshake outputs 0. The in-flight transaction is abandoned; the bus side is reset by the same iReset.
- No combinational path from iAxi* inputs to oAxi* outputs. AR outputs depend only on state, owner and requester inputs.

Test Plan:
- IFU only, addr 0x8000_0000, bus AR ready 1 cycle later, R data 0xDEADBEEF after 2 cycles → oIfuArReady pulses once; oIfuRValid=1 with data 0xDEADBEEF, resp 0; oLsuRValid stays 0; state returns to IDLE.
- IFU and LSU assert ArValid in the same cycle right after reset → IFU granted first (oAxiArAddr = IFU addr); LSU granted after IFU's R handshake; third tie → IFU.
- Both requesters held for 6 transactions → grant order IFU, LSU, IFU, LSU, IFU, LSU; each gets 3 RValid pulses.
- LSU owns the bus, iAxiRValid=1 while iLsuRReady=0 for 3 cycles → oAxiRReady=0 and state stays DATA; completes the cycle iLsuRReady rises; a concurrent IFU request waits with oIfuArReady=0.
- iAxiArReady held 0 for 5 cycles in ADDR → oAxiArValid stays 1 with a stable address; no state change.
- iReset asserted during DATA → next cycle all valid/ready outputs 0, state IDLE; the next IFU request is granted normally.
